// File: rtl/cache_arb_pkg.sv
// ---------------------------------------------------------------------------
// cache_arb_pkg
// Shared definitions for the icache/dcache -> AXI controller arbiter:
//   - arb_state_e : arbiter session states
//   - MST_IC/MST_DC : master ids; also the bit positions in the one-hot grant
//   - AXI_READ/AXI_WRITE : encodings of the controller's direction input
// ---------------------------------------------------------------------------
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GNT_IC  = 2'd1,
    ARB_GNT_DC  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  localparam logic MST_IC = 1'b0;
  localparam logic MST_DC = 1'b1;

  localparam logic AXI_READ  = 1'b0;
  localparam logic AXI_WRITE = 1'b1;

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_axi_arbiter_if
// Bundles every signal between the two caches, the arbiter and axi_ctl.
//   modport master : the arbiter's view (it masters the AXI controller)
//       in : ic_req/ic_addr/ic_fifo_idx/ic_fifo_done,
//            dc_req/dc_rw/dc_addr/dc_fifo_wen/dc_wdata/dc_fifo_idx/dc_fifo_done,
//            axi_done/axi_data_i
//       out: ic_done/ic_data, dc_done/dc_rdata,
//            axi_req/axi_rw/axi_req_addr/axi_fifo_wen/axi_data_o/
//            axi_fifo_idx/axi_fifo_done
//   modport slave  : the surrounding caches and axi_ctl (directions mirrored)
// Parameters: ADDR_W request address, DATA_W fifo data, IDX_W fifo index.
// ---------------------------------------------------------------------------
interface cache_axi_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int IDX_W  = 9
);

  // icache side
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [IDX_W-1:0]  ic_fifo_idx;
  logic              ic_fifo_done;
  logic              ic_done;
  logic [DATA_W-1:0] ic_data;

  // dcache side
  logic              dc_req;
  logic              dc_rw;
  logic [ADDR_W-1:0] dc_addr;
  logic              dc_fifo_wen;
  logic [DATA_W-1:0] dc_wdata;
  logic [IDX_W-1:0]  dc_fifo_idx;
  logic              dc_fifo_done;
  logic              dc_done;
  logic [DATA_W-1:0] dc_rdata;

  // axi_ctl side
  logic              axi_req;
  logic              axi_rw;
  logic [ADDR_W-1:0] axi_req_addr;
  logic              axi_fifo_wen;
  logic [DATA_W-1:0] axi_data_o;
  logic [IDX_W-1:0]  axi_fifo_idx;
  logic              axi_fifo_done;
  logic              axi_done;
  logic [DATA_W-1:0] axi_data_i;

  modport master (
    input  ic_req, ic_addr, ic_fifo_idx, ic_fifo_done,
    output ic_done, ic_data,
    input  dc_req, dc_rw, dc_addr, dc_fifo_wen, dc_wdata, dc_fifo_idx, dc_fifo_done,
    output dc_done, dc_rdata,
    output axi_req, axi_rw, axi_req_addr, axi_fifo_wen, axi_data_o,
    output axi_fifo_idx, axi_fifo_done,
    input  axi_done, axi_data_i
  );

  modport slave (
    output ic_req, ic_addr, ic_fifo_idx, ic_fifo_done,
    input  ic_done, ic_data,
    output dc_req, dc_rw, dc_addr, dc_fifo_wen, dc_wdata, dc_fifo_idx, dc_fifo_done,
    input  dc_done, dc_rdata,
    input  axi_req, axi_rw, axi_req_addr, axi_fifo_wen, axi_data_o,
    input  axi_fifo_idx, axi_fifo_done,
    output axi_done, axi_data_i
  );

endinterface

// File: rtl/cache_arb_pick.sv
// ---------------------------------------------------------------------------
// cache_arb_pick
// Combinational grant selection among pending cache requests.
//   ic_req, dc_req : pending requests
//   rr_last        : master granted most recently (only with CACHE_ARB_RR_EN)
//   gnt            : one-hot next grant, bit MST_DC / bit MST_IC; 00 = none
// Configuration macro CACHE_ARB_RR_EN:
//   defined   -> round-robin, a tie goes to the master not granted last
//   undefined -> fixed priority, dcache over icache
// ---------------------------------------------------------------------------
module cache_arb_pick
  import cache_arb_pkg::*;
(
  input  logic       ic_req,
  input  logic       dc_req,
`ifdef CACHE_ARB_RR_EN
  input  logic       rr_last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
`ifdef CACHE_ARB_RR_EN
    if (ic_req && dc_req) begin
      if (rr_last == MST_IC) gnt[MST_DC] = 1'b1;
      else                   gnt[MST_IC] = 1'b1;
    end else begin
      gnt[MST_DC] = dc_req;
      gnt[MST_IC] = ic_req;
    end
`else
    // The core stalls on the dcache anyway, so icache starvation is accepted.
    if (dc_req) gnt[MST_DC] = 1'b1;
    else        gnt[MST_IC] = ic_req;
`endif
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// cache_axi_arbiter
// Shares the single AXI controller between the icache (read-only refill) and
// the dcache (dirty write-back + refill). One cache at a time owns an
// exclusive session that lasts until it pulses its fifo_done; a one-cycle
// release gap follows so axi_ctl sees req low before the next session.
// Ports:
//   clk     : clock
//   rst     : asynchronous, active-high reset
//   bus     : cache_axi_arbiter_if.master (both caches + axi_ctl signals)
//   grant_o : {dc, ic} one-hot current grant, 00 = none
// Parameters: ADDR_W, DATA_W, IDX_W (must match the interface instance).
// Configuration: CACHE_ARB_RR_EN selects round-robin instead of dc > ic.
// Only the state (and rr_last) is registered; all outputs decode from it, so
// reset clears every output without waiting for a clock edge.
// ---------------------------------------------------------------------------
module cache_axi_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int IDX_W  = 9
) (
  input  logic                clk,
  input  logic                rst,
  cache_axi_arbiter_if.master bus,
  output logic [1:0]          grant_o
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [1:0]        pick_gnt;
  logic              gnt_ic;
  logic              gnt_dc;

  logic              req_mux;
  logic              rw_mux;
  logic              wen_mux;
  logic              fifo_done_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic [IDX_W-1:0]  idx_mux;
  logic [DATA_W-1:0] ic_data_ret;
  logic [DATA_W-1:0] dc_data_ret;

`ifdef CACHE_ARB_RR_EN
  logic rr_last;

  // Reset value IC makes dcache win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= MST_IC;
    end else if (state == ARB_IDLE && pick_gnt != 2'b00) begin
      rr_last <= pick_gnt[MST_DC] ? MST_DC : MST_IC;
    end
  end

  cache_arb_pick u_pick (
    .ic_req  (bus.ic_req),
    .dc_req  (bus.dc_req),
    .rr_last (rr_last),
    .gnt     (pick_gnt)
  );
`else
  cache_arb_pick u_pick (
    .ic_req  (bus.ic_req),
    .dc_req  (bus.dc_req),
    .gnt     (pick_gnt)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    gnt_ic        = (state == ARB_GNT_IC);
    gnt_dc        = (state == ARB_GNT_DC);
    req_mux       = 1'b0;
    rw_mux        = AXI_READ;
    wen_mux       = 1'b0;
    fifo_done_mux = 1'b0;
    addr_mux      = '0;
    wdata_mux     = '0;
    idx_mux       = '0;
    ic_data_ret   = '0;
    dc_data_ret   = '0;

    case (state)
      ARB_IDLE: begin
        if (pick_gnt[MST_DC])      state_nxt = ARB_GNT_DC;
        else if (pick_gnt[MST_IC]) state_nxt = ARB_GNT_IC;
      end
      ARB_GNT_IC: begin
        // icache only refills: direction and fifo write enable are forced off.
        req_mux       = bus.ic_req;
        addr_mux      = bus.ic_addr;
        idx_mux       = bus.ic_fifo_idx;
        fifo_done_mux = bus.ic_fifo_done;
        ic_data_ret   = bus.axi_data_i;
        if (bus.ic_fifo_done) state_nxt = ARB_RELEASE;
      end
      ARB_GNT_DC: begin
        // dc_rw may flip write-back -> refill inside one session; no regrant.
        req_mux       = bus.dc_req;
        rw_mux        = (bus.dc_rw == AXI_WRITE) ? AXI_WRITE : AXI_READ;
        wen_mux       = bus.dc_fifo_wen;
        addr_mux      = bus.dc_addr;
        wdata_mux     = bus.dc_wdata;
        idx_mux       = bus.dc_fifo_idx;
        fifo_done_mux = bus.dc_fifo_done;
        dc_data_ret   = bus.axi_data_i;
        if (bus.dc_fifo_done) state_nxt = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        // Requests are not sampled here; they are picked up in IDLE.
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign bus.axi_req       = req_mux;
  assign bus.axi_rw        = rw_mux;
  assign bus.axi_req_addr  = addr_mux;
  assign bus.axi_fifo_wen  = wen_mux;
  assign bus.axi_data_o    = wdata_mux;
  assign bus.axi_fifo_idx  = idx_mux;
  assign bus.axi_fifo_done = fifo_done_mux;

  assign bus.ic_done  = gnt_ic & bus.axi_done;
  assign bus.ic_data  = ic_data_ret;
  assign bus.dc_done  = gnt_dc & bus.axi_done;
  assign bus.dc_rdata = dc_data_ret;

  assign grant_o = {gnt_dc, gnt_ic};

  // A granted cache must hold req until the cycle it pulses fifo_done;
  // dropping it early leaves the grant stuck and is a protocol violation.
  a_ic_req_held: assert property (@(posedge clk) disable iff (rst)
                                  gnt_ic |-> (bus.ic_req || bus.ic_fifo_done));
  a_dc_req_held: assert property (@(posedge clk) disable iff (rst)
                                  gnt_dc |-> (bus.dc_req || bus.dc_fifo_done));

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_axi_arbiter
// Directed scenarios followed by a randomized phase. A session-level model
// (who owns the controller, whether the release gap is pending, who was
// granted last) predicts grant_o and every routed output each cycle.
// Build with or without CACHE_ARB_RR_EN; tie expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_cache_axi_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 9;

`ifdef CACHE_ARB_RR_EN
  localparam logic [1:0] TIE2_EXP = 2'b01;
`else
  localparam logic [1:0] TIE2_EXP = 2'b10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant_o;

  cache_axi_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  cache_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .grant_o (grant_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: owner 0 = nobody, 1 = icache, 2 = dcache.
  int owner = 0;
  bit in_gap = 1'b0;
`ifdef CACHE_ARB_RR_EN
  int last_owner = 1;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = 0;
    in_gap = 1'b0;
`ifdef CACHE_ARB_RR_EN
    last_owner = 1;
`endif
  endtask

  // Session rules applied at a clock edge using the inputs held before it.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (in_gap) begin
      in_gap = 1'b0;
    end else if (owner == 0) begin
      if (bus.ic_req && bus.dc_req) begin
`ifdef CACHE_ARB_RR_EN
        owner = (last_owner == 2) ? 1 : 2;
`else
        owner = 2;
`endif
      end else if (bus.dc_req) owner = 2;
      else if (bus.ic_req)     owner = 1;
`ifdef CACHE_ARB_RR_EN
      if (owner != 0) last_owner = owner;
`endif
    end else if ((owner == 1 && bus.ic_fifo_done) || (owner == 2 && bus.dc_fifo_done)) begin
      owner  = 0;
      in_gap = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] e_req, e_rw, e_addr, e_wen, e_wd, e_idx, e_fd;
    e_req = 0; e_rw = 0; e_addr = 0; e_wen = 0; e_wd = 0; e_idx = 0; e_fd = 0;
    if (owner == 1) begin
      e_req = 64'(bus.ic_req); e_addr = bus.ic_addr;
      e_idx = 64'(bus.ic_fifo_idx); e_fd = 64'(bus.ic_fifo_done);
    end else if (owner == 2) begin
      e_req = 64'(bus.dc_req); e_rw = 64'(bus.dc_rw); e_addr = bus.dc_addr;
      e_wen = 64'(bus.dc_fifo_wen); e_wd = bus.dc_wdata;
      e_idx = 64'(bus.dc_fifo_idx); e_fd = 64'(bus.dc_fifo_done);
    end
    chk({tag, ":grant"},     64'(grant_o), (owner == 1) ? 64'd1 : (owner == 2) ? 64'd2 : 64'd0);
    chk({tag, ":axi_req"},   64'(bus.axi_req), e_req);
    chk({tag, ":axi_rw"},    64'(bus.axi_rw), e_rw);
    chk({tag, ":axi_addr"},  bus.axi_req_addr, e_addr);
    chk({tag, ":axi_wen"},   64'(bus.axi_fifo_wen), e_wen);
    chk({tag, ":axi_dout"},  bus.axi_data_o, e_wd);
    chk({tag, ":axi_idx"},   64'(bus.axi_fifo_idx), e_idx);
    chk({tag, ":axi_fdone"}, 64'(bus.axi_fifo_done), e_fd);
    chk({tag, ":ic_done"},   64'(bus.ic_done), (owner == 1) ? 64'(bus.axi_done) : 64'd0);
    chk({tag, ":ic_data"},   bus.ic_data, (owner == 1) ? bus.axi_data_i : 64'd0);
    chk({tag, ":dc_done"},   64'(bus.dc_done), (owner == 2) ? 64'(bus.axi_done) : 64'd0);
    chk({tag, ":dc_rdata"},  bus.dc_rdata, (owner == 2) ? bus.axi_data_i : 64'd0);
  endtask

  // Check the settled outputs, advance the model, cross one clock edge.
  task automatic cycle(input string tag);
    #1;
    check_outputs(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Finish whatever session the model says is active (fifo_done, drop req).
  task automatic end_session(input string tag);
    if (owner == 1) begin
      bus.ic_fifo_done = 1'b1;
      cycle(tag);
      bus.ic_fifo_done = 1'b0;
      bus.ic_req       = 1'b0;
    end else if (owner == 2) begin
      bus.dc_fifo_done = 1'b1;
      cycle(tag);
      bus.dc_fifo_done = 1'b0;
      bus.dc_req       = 1'b0;
    end else begin
      cycle(tag);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  int  ic_cnt;
  bit  ic_ending, dc_ending;

  initial begin
    rst = 1'b1;
    bus.ic_req = 0; bus.ic_addr = 0; bus.ic_fifo_idx = 0; bus.ic_fifo_done = 0;
    bus.dc_req = 0; bus.dc_rw = 0; bus.dc_addr = 0; bus.dc_fifo_wen = 0;
    bus.dc_wdata = 0; bus.dc_fifo_idx = 0; bus.dc_fifo_done = 0;
    bus.axi_done = 0; bus.axi_data_i = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset_grant", 64'(grant_o), 64'd0);
    rst = 1'b0;

    // icache alone: 8 refill beats, then end of session
    bus.ic_req = 1'b1; bus.ic_addr = rnd64();
    #1;
    chk("ic_req_latency", 64'(bus.axi_req), 64'd0);
    cycle("ic_idle");
    chk("ic_grant", 64'(grant_o), 64'd1);
    chk("ic_axi_req", 64'(bus.axi_req), 64'd1);
    ic_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.axi_done = 1'b1; bus.axi_data_i = rnd64(); bus.ic_fifo_idx = IDX_W'(i);
      #1;
      if (bus.ic_done === 1'b1) ic_cnt++;
      chk("ic_beat_dc_done", 64'(bus.dc_done), 64'd0);
      cycle("ic_beat");
    end
    chk("ic_done_count", 64'(ic_cnt), 64'd8);
    bus.axi_done = 1'b0; bus.ic_fifo_done = 1'b1;
    #1;
    chk("ic_axi_fdone", 64'(bus.axi_fifo_done), 64'd1);
    cycle("ic_end");
    bus.ic_fifo_done = 1'b0; bus.ic_req = 1'b0;
    chk("ic_rel_grant", 64'(grant_o), 64'd0);
    chk("ic_rel_req", 64'(bus.axi_req), 64'd0);
    cycle("ic_rel");
    cycle("ic_idle2");

    // tie, then a second tie right after the release
    bus.ic_req = 1'b1; bus.dc_req = 1'b1;
    bus.ic_addr = rnd64(); bus.dc_addr = rnd64();
    cycle("tie1_idle");
    chk("tie1_grant", 64'(grant_o), 64'd2);
    cycle("tie1_s");
    bus.dc_fifo_done = 1'b1;
    cycle("tie1_end");
    bus.dc_fifo_done = 1'b0;
    chk("tie1_rel_grant", 64'(grant_o), 64'd0);
    cycle("tie1_rel");
    cycle("tie2_idle");
    chk("tie2_grant", 64'(grant_o), 64'(TIE2_EXP));
    end_session("tie2_end");
    cycle("tie2_rel");
    cycle("tie2_idle2");
    end_session("tie3_end");
    cycle("tie3_rel");
    cycle("tie3_idle");

    // dcache dirty write-back then refill in one session
    bus.dc_req = 1'b1; bus.dc_rw = 1'b1; bus.dc_addr = rnd64();
    cycle("dc_idle");
    chk("dc_grant", 64'(grant_o), 64'd2);
    chk("dc_rw_wr", 64'(bus.axi_rw), 64'd1);
    for (int i = 0; i < 8; i++) begin
      bus.dc_fifo_wen = 1'b1; bus.dc_wdata = rnd64(); bus.dc_fifo_idx = IDX_W'(i);
      cycle("dc_wb");
      chk("dc_grant_wb", 64'(grant_o), 64'd2);
    end
    bus.dc_fifo_wen = 1'b0; bus.axi_done = 1'b1;
    cycle("dc_wb_done");
    bus.axi_done = 1'b0; bus.dc_rw = 1'b0; bus.dc_addr = rnd64();
    #1;
    chk("dc_rw_rd", 64'(bus.axi_rw), 64'd0);
    chk("dc_grant_flip", 64'(grant_o), 64'd2);
    for (int i = 0; i < 8; i++) begin
      bus.axi_done = 1'b1; bus.axi_data_i = rnd64(); bus.dc_fifo_idx = IDX_W'(i);
      cycle("dc_refill");
      chk("dc_grant_rf", 64'(grant_o), 64'd2);
    end
    bus.axi_done = 1'b0;
    end_session("dc_end");
    chk("dc_rel_grant", 64'(grant_o), 64'd0);
    cycle("dc_rel");
    cycle("dc_idle2");

    // dc granted; ic requests and pulses a stray fifo_done; then back-to-back
    bus.dc_req = 1'b1; bus.dc_rw = 1'b0;
    cycle("nb_idle");
    bus.ic_req = 1'b1; bus.ic_fifo_done = 1'b1;
    cycle("nb_stray");
    bus.ic_fifo_done = 1'b0;
    chk("nb_grant_kept", 64'(grant_o), 64'd2);
    for (int i = 0; i < 4; i++) begin
      bus.axi_done = 1'b1; bus.axi_data_i = rnd64();
      #1;
      chk("nb_ic_done", 64'(bus.ic_done), 64'd0);
      chk("nb_dc_done", 64'(bus.dc_done), 64'd1);
      cycle("nb_beat");
    end
    bus.axi_done = 1'b0;
    end_session("nb_end");
    chk("b2b_rel_req", 64'(bus.axi_req), 64'd0);
    chk("b2b_rel_grant", 64'(grant_o), 64'd0);
    cycle("b2b_rel");
    cycle("b2b_idle");
    chk("b2b_ic_grant", 64'(grant_o), 64'd1);
    chk("b2b_ic_req", 64'(bus.axi_req), 64'd1);
    end_session("b2b_end");
    cycle("b2b_rel2");
    cycle("b2b_idle2");

    // asynchronous reset in the middle of a dcache session
    bus.dc_req = 1'b1; bus.dc_addr = rnd64();
    cycle("rs_idle");
    chk("rs_grant", 64'(grant_o), 64'd2);
    bus.axi_done = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rs_async_req", 64'(bus.axi_req), 64'd0);
    chk("rs_async_grant", 64'(grant_o), 64'd0);
    check_outputs("rs_async");
    bus.dc_req = 1'b0; bus.axi_done = 1'b0;
    model_edge();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("rs_after");
    chk("rs_idle_grant", 64'(grant_o), 64'd0);
    // both re-request: rr_last is back to IC, so dc wins in either build
    bus.ic_req = 1'b1; bus.dc_req = 1'b1;
    cycle("rs_tie");
    chk("rs_tie_grant", 64'(grant_o), 64'd2);
    end_session("rs_end1");
    cycle("rs_rel1");
    cycle("rs_idle1");
    end_session("rs_end2");
    cycle("rs_rel2");
    cycle("rs_idle2");

    // randomized traffic from two protocol-abiding caches
    ic_ending = 1'b0; dc_ending = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      bus.ic_fifo_done = 1'b0;
      if (ic_ending) begin
        bus.ic_req = 1'b0; ic_ending = 1'b0;
      end else if (!bus.ic_req) begin
        bus.ic_req = ($urandom_range(0, 3) == 0);
      end else if (owner == 1 && $urandom_range(0, 7) == 0) begin
        bus.ic_fifo_done = 1'b1; ic_ending = 1'b1;
      end else if (owner != 1 && $urandom_range(0, 9) == 0) begin
        bus.ic_fifo_done = 1'b1;
      end
      bus.dc_fifo_done = 1'b0;
      if (dc_ending) begin
        bus.dc_req = 1'b0; dc_ending = 1'b0;
      end else if (!bus.dc_req) begin
        bus.dc_req = ($urandom_range(0, 3) == 0);
      end else if (owner == 2 && $urandom_range(0, 7) == 0) begin
        bus.dc_fifo_done = 1'b1; dc_ending = 1'b1;
      end else if (owner != 2 && $urandom_range(0, 9) == 0) begin
        bus.dc_fifo_done = 1'b1;
      end
      bus.ic_addr     = rnd64();
      bus.ic_fifo_idx = IDX_W'($urandom);
      bus.dc_rw       = 1'($urandom);
      bus.dc_addr     = rnd64();
      bus.dc_fifo_wen = 1'($urandom);
      bus.dc_wdata    = rnd64();
      bus.dc_fifo_idx = IDX_W'($urandom);
      bus.axi_done    = 1'($urandom);
      bus.axi_data_i  = rnd64();
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
